// File: rtl/nes_palette_ram_wr_if.sv
// CPU register bus and render read port of the writable NES palette, plus FSM/address debug taps.
// Handshake: cpu_we/cpu_rd are single-cycle strobes that are always accepted (no ready);
// rd_addr is sampled every clock and its result appears on rd_dout one clock later.
interface nes_palette_ram_wr_if;
  logic        cpu_we;
  logic        cpu_rd;
  logic [2:0]  cpu_sel;
  logic [7:0]  cpu_din;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_dout;
  logic        init_busy;
  logic        dbg_state;   // 0 = INIT, 1 = RUN
  logic [13:0] dbg_vaddr;

  modport master (
    output cpu_we, cpu_rd, cpu_sel, cpu_din, rd_addr,
    input  rd_dout, init_busy, dbg_state, dbg_vaddr
  );

  modport slave (
    input  cpu_we, cpu_rd, cpu_sel, cpu_din, rd_addr,
    output rd_dout, init_busy, dbg_state, dbg_vaddr
  );
endinterface

// File: rtl/nes_palette_ram_wr.sv
// Writable 32x6 NES palette loaded through PPUCTRL/PPUSTATUS/PPUADDR/PPUDATA, cleared after reset.
// Optional macro PALETTE_MIRROR_EN folds indices $10/$14/$18/$1C onto $00/$04/$08/$0C.
module nes_palette_ram_wr #(
  parameter logic [7:0] INIT_COLOR = 8'h0F
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nes_palette_ram_wr_if.slave  bus
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic [13:0] vaddr_q;
  logic        w_latch_q;
  logic        inc32_q;
  logic [7:0]  rd_dout_q;
  logic [5:0]  mem_q [32];

  logic        run;
  logic        wr_strobe;
  logic        rd_strobe;
  logic        pal_wr;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [5:0]  mem_wdata;
  logic [13:0] vaddr_step;

  function automatic logic [4:0] mirror_idx(input logic [4:0] a);
`ifdef PALETTE_MIRROR_EN
    mirror_idx = (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
`else
    mirror_idx = a;
`endif
  endfunction

  // CPU strobes only take effect once the clear sequence has finished.
  always_comb begin
    run        = (state_q == ST_RUN);
    wr_strobe  = run && bus.cpu_we;
    rd_strobe  = run && bus.cpu_rd && !bus.cpu_we;
    pal_wr     = wr_strobe && (bus.cpu_sel == 3'd7) && (vaddr_q[13:8] == 6'h3F);
    mem_we     = !run || pal_wr;
    mem_waddr  = run ? mirror_idx(vaddr_q[4:0]) : cnt_q;
    mem_wdata  = run ? bus.cpu_din[5:0] : INIT_COLOR[5:0];
    vaddr_step = inc32_q ? 14'd32 : 14'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b1;
      vaddr_q   <= 14'd0;
      w_latch_q <= 1'b0;
      inc32_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            busy_q  <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (wr_strobe) begin
            case (bus.cpu_sel)
              3'd0: inc32_q <= bus.cpu_din[2];
              3'd6: begin
                if (!w_latch_q) begin
                  vaddr_q[13:8] <= bus.cpu_din[5:0];
                  w_latch_q     <= 1'b1;
                end else begin
                  vaddr_q[7:0]  <= bus.cpu_din;
                  w_latch_q     <= 1'b0;
                end
              end
              3'd7:    vaddr_q <= vaddr_q + vaddr_step;
              default: ;
            endcase
          end else if (rd_strobe && (bus.cpu_sel == 3'd2)) begin
            w_latch_q <= 1'b0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Storage is not reset; the INIT walk clears it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Non-blocking read of the array gives read-before-write on a same-entry collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_dout_q <= 8'h00;
    else        rd_dout_q <= {2'b00, mem_q[mirror_idx(bus.rd_addr)]};
  end

  assign bus.rd_dout   = rd_dout_q;
  assign bus.init_busy = busy_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_vaddr = vaddr_q;

endmodule

// File: tb/tb_nes_palette_ram_wr.sv
// Self-checking bench for nes_palette_ram_wr: scenario tasks plus a read-data scoreboard.
module tb_nes_palette_ram_wr;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  nes_palette_ram_wr_if bus ();

  nes_palette_ram_wr #(.INIT_COLOR(8'h0F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [7:0]  exp_q [$];
  logic [5:0]  m_mem [32];
  logic [13:0] m_vaddr;
  logic        m_wl;
  logic        m_inc32;

  function automatic logic [4:0] m_mirror(input logic [4:0] a);
`ifdef PALETTE_MIRROR_EN
    if (a[4] && (a[1:0] == 2'b00)) return {1'b0, a[3:0]};
`endif
    return a;
  endfunction

  task automatic model_clear();
    m_vaddr = 14'd0;
    m_wl    = 1'b0;
    m_inc32 = 1'b0;
    for (int i = 0; i < 32; i++) m_mem[i] = 6'h0F;
  endtask

  // ---------------- drivers (called at a negedge) ----------------
  task automatic idle_inputs();
    bus.cpu_we  = 1'b0;
    bus.cpu_rd  = 1'b0;
    bus.cpu_sel = 3'd0;
    bus.cpu_din = 8'h00;
  endtask

  task automatic cpu_write(input logic [2:0] sel, input logic [7:0] din);
    bus.cpu_we  = 1'b1;
    bus.cpu_sel = sel;
    bus.cpu_din = din;
    case (sel)
      3'd0: m_inc32 = din[2];
      3'd6: begin
        if (!m_wl) begin m_vaddr[13:8] = din[5:0]; m_wl = 1'b1; end
        else       begin m_vaddr[7:0]  = din;      m_wl = 1'b0; end
      end
      3'd7: begin
        if (m_vaddr[13:8] == 6'h3F) m_mem[m_mirror(m_vaddr[4:0])] = din[5:0];
        m_vaddr = m_vaddr + (m_inc32 ? 14'd32 : 14'd1);
      end
      default: ;
    endcase
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic cpu_read(input logic [2:0] sel);
    bus.cpu_rd  = 1'b1;
    bus.cpu_sel = sel;
    if (sel == 3'd2) m_wl = 1'b0;
    @(negedge clk);
    idle_inputs();
  endtask

  // ---------------- scoreboard ----------------
  task automatic sb_pop_compare(input string name);
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, actual=%02h required=queued entry", name, bus.rd_dout);
    end else begin
      e = exp_q.pop_front();
      if (bus.rd_dout !== e) begin
        errors++;
        $display("FAIL %s: rd_dout actual=%02h required=%02h", name, bus.rd_dout, e);
      end
    end
  endtask

  task automatic read_idx(input logic [4:0] idx, input string name);
    bus.rd_addr = idx;
    exp_q.push_back({2'b00, m_mem[m_mirror(idx)]});
    @(negedge clk);
    sb_pop_compare(name);
  endtask

  // Counts negedges with init_busy high, optionally poking CPU strobes during INIT.
  task automatic count_busy(input bit poke, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.init_busy !== 1'b1) break;
      n++;
      idle_inputs();
      if (poke) begin
        case (i)
          0: begin bus.cpu_we = 1'b1; bus.cpu_sel = 3'd6; bus.cpu_din = 8'h3F; end
          1: begin bus.cpu_we = 1'b1; bus.cpu_sel = 3'd6; bus.cpu_din = 8'h00; end
          2: begin bus.cpu_we = 1'b1; bus.cpu_sel = 3'd7; bus.cpu_din = 8'h11; end
          3: begin bus.cpu_we = 1'b1; bus.cpu_sel = 3'd0; bus.cpu_din = 8'h04; end
          4: begin bus.cpu_rd = 1'b1; bus.cpu_sel = 3'd2; end
          default: ;
        endcase
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n;
    idle_inputs();
    bus.rd_addr = 5'd5;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rd_dout !== 8'h00)      begin errors++; $display("FAIL reset_dout: actual=%02h required=00", bus.rd_dout); end
    checks++;
    if (bus.init_busy !== 1'b1)     begin errors++; $display("FAIL reset_busy: actual=%b required=1", bus.init_busy); end
    checks++;
    if (bus.dbg_vaddr !== 14'h0000) begin errors++; $display("FAIL reset_vaddr: actual=%04h required=0000", bus.dbg_vaddr); end
    checks++;
    if (bus.dbg_state !== 1'b0)     begin errors++; $display("FAIL reset_state: actual=%b required=0", bus.dbg_state); end
    rst_n = 1'b1;
    count_busy(1'b0, n);
    checks++;
    if (n != 32) begin errors++; $display("FAIL init_len: busy cycles actual=%0d required=32", n); end
    checks++;
    if (bus.rd_dout !== 8'h0F)  begin errors++; $display("FAIL init_dout5: actual=%02h required=0F", bus.rd_dout); end
    checks++;
    if (bus.dbg_state !== 1'b1) begin errors++; $display("FAIL run_state: actual=%b required=1", bus.dbg_state); end
  endtask

  task automatic test_init_restart();
    int n;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (bus.init_busy !== 1'b1) begin errors++; $display("FAIL mid_init_busy: actual=%b required=1", bus.init_busy); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dbg_state !== 1'b0) begin errors++; $display("FAIL mid_reset_state: actual=%b required=0", bus.dbg_state); end
    rst_n = 1'b1;
    count_busy(1'b1, n);
    checks++;
    if (n != 32) begin errors++; $display("FAIL restart_len: busy cycles actual=%0d required=32", n); end
    checks++;
    if (bus.dbg_vaddr !== 14'h0000) begin errors++; $display("FAIL init_ignores_cpu: vaddr actual=%04h required=0000", bus.dbg_vaddr); end
    model_clear();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 32; i++) read_idx(5'(i), "clear_contents");
  endtask

  task automatic test_load();
    cpu_write(3'd6, 8'h3F);
    cpu_write(3'd6, 8'h00);
    cpu_write(3'd7, 8'h31);
    cpu_write(3'd7, 8'h1B);
    cpu_write(3'd7, 8'h2B);
    cpu_write(3'd7, 8'h37);
    checks++;
    if (bus.dbg_vaddr !== 14'h3F04) begin errors++; $display("FAIL load_vaddr: actual=%04h required=3F04", bus.dbg_vaddr); end
    for (int i = 0; i < 4; i++) read_idx(5'(i), "load_readback");
  endtask

  task automatic test_inc32_wrap();
    cpu_write(3'd0, 8'h04);
    cpu_write(3'd6, 8'h3F);
    cpu_write(3'd6, 8'hF0);
    cpu_write(3'd7, 8'h12);
    checks++;
    if (bus.dbg_vaddr !== 14'h0010) begin errors++; $display("FAIL wrap_vaddr: actual=%04h required=0010", bus.dbg_vaddr); end
    cpu_write(3'd7, 8'h2A);
    checks++;
    if (bus.dbg_vaddr !== 14'h0030) begin errors++; $display("FAIL nonpal_vaddr: actual=%04h required=0030", bus.dbg_vaddr); end
    cpu_write(3'd0, 8'h00);
    bus.rd_addr = 5'h10;
    @(negedge clk);
    checks++;
    if (bus.rd_dout !== 8'h12) begin errors++; $display("FAIL inc32_idx10: actual=%02h required=12", bus.rd_dout); end
    for (int i = 0; i < 32; i++) read_idx(5'(i), "nonpal_unchanged");
  endtask

  task automatic test_latch_reset();
    cpu_write(3'd6, 8'h3F);
    cpu_read(3'd2);
    cpu_write(3'd6, 8'h3F);
    cpu_write(3'd6, 8'h05);
    cpu_write(3'd7, 8'h16);
    checks++;
    if (bus.dbg_vaddr !== 14'h3F06) begin errors++; $display("FAIL latch_vaddr: actual=%04h required=3F06", bus.dbg_vaddr); end
    bus.rd_addr = 5'd5;
    @(negedge clk);
    checks++;
    if (bus.rd_dout !== 8'h16) begin errors++; $display("FAIL latch_idx5: actual=%02h required=16", bus.rd_dout); end
  endtask

  task automatic test_collision();
    cpu_write(3'd6, 8'h3F);
    cpu_write(3'd6, 8'h03);
    bus.rd_addr = 5'd3;
    bus.cpu_we  = 1'b1;
    bus.cpu_sel = 3'd7;
    bus.cpu_din = 8'h30;
    exp_q.push_back({2'b00, m_mem[3]});
    m_mem[m_mirror(5'd3)] = 6'h30;
    m_vaddr = m_vaddr + 14'd1;
    @(negedge clk);
    idle_inputs();
    sb_pop_compare("collision_old");
    exp_q.push_back({2'b00, m_mem[3]});
    @(negedge clk);
    sb_pop_compare("collision_new");
    checks++;
    if (bus.rd_dout !== 8'h30) begin errors++; $display("FAIL collision_const: actual=%02h required=30", bus.rd_dout); end
  endtask

  task automatic test_mirror();
    cpu_write(3'd6, 8'h3F);
    cpu_write(3'd6, 8'h10);
    cpu_write(3'd7, 8'h2D);
    read_idx(5'h00, "mirror_idx00");
    read_idx(5'h10, "mirror_idx10");
    bus.rd_addr = 5'h00;
    @(negedge clk);
    checks++;
`ifdef PALETTE_MIRROR_EN
    if (bus.rd_dout !== 8'h2D) begin errors++; $display("FAIL mirror_const00: actual=%02h required=2D", bus.rd_dout); end
`else
    if (bus.rd_dout !== 8'h31) begin errors++; $display("FAIL mirror_const00: actual=%02h required=31", bus.rd_dout); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [4:0] idx;
    for (int i = 0; i < 16; i++) begin
      idx = 5'($urandom_range(0, 31));
      cpu_write(3'd6, 8'h3F);
      cpu_write(3'd6, {3'b000, idx});
      cpu_write(3'd7, 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 40; i++) begin
      if (i > 0) sb_pop_compare("b2b_read");
      idx = 5'($urandom_range(0, 31));
      bus.rd_addr = idx;
      exp_q.push_back({2'b00, m_mem[m_mirror(idx)]});
      @(negedge clk);
    end
    sb_pop_compare("b2b_read");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    bus.rd_addr = 5'd0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_init_restart();
    test_clear();
    test_load();
    test_inc32_wrap();
    test_latch_reset();
    test_collision();
    test_mirror();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: entries actual=%0d required=0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
